sonic_vc_packet_arbiter: RTL and testbench



---
 rtl/sonic_vc_packet_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sonic_vc_packet_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_vc_packet_arbiter.sv
// rtl/sonic_vc_packet_arbiter.sv - two-channel packet-granular round-robin stream arbiter
//
// Merges two packet streams (virtual channels 0 and 1) onto one registered output
// stream. A packet is never interleaved with the other channel. Each output beat is
// tagged with its source channel.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in0_* / in1_*           per-channel input streams (valid/ready/data/sop/eop/empty)
//   out_*                   merged output stream plus out_channel source tag
//   pkt_count0/1            EOP beats accepted per channel (only with SONIC_VC_ARB_PKT_COUNT_EN)
//   pkt_count_clear         zeroes both packet counters (only with SONIC_VC_ARB_PKT_COUNT_EN)
//
// Optional feature macro: SONIC_VC_ARB_PKT_COUNT_EN

module sonic_vc_packet_arbiter #(
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   in0_valid,
    output logic                   in0_ready,
    input  logic [DATA_WIDTH-1:0]  in0_data,
    input  logic                   in0_startofpacket,
    input  logic                   in0_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in0_empty,

    input  logic                   in1_valid,
    output logic                   in1_ready,
    input  logic [DATA_WIDTH-1:0]  in1_data,
    input  logic                   in1_startofpacket,
    input  logic                   in1_endofpacket,
    input  logic [EMPTY_WIDTH-1:0] in1_empty,

`ifdef SONIC_VC_ARB_PKT_COUNT_EN
    input  logic                   pkt_count_clear,
    output logic [31:0]            pkt_count0,
    output logic [31:0]            pkt_count1,
`endif

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_channel,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [EMPTY_WIDTH-1:0] out_empty
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;

    logic                   out_valid_q;
    logic                   out_channel_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_sop_q;
    logic                   out_eop_q;
    logic [EMPTY_WIDTH-1:0] out_empty_q;

    logic                   pipe_ready;
    logic                   acc0;
    logic                   acc1;

    // The output slice can take a beat when it is empty or being drained this cycle.
    assign pipe_ready = out_ready || !out_valid_q;

    assign acc0 = in0_valid && in0_ready;
    assign acc1 = in1_valid && in1_ready;

    // Ready / next-state. In IDLE a channel's ready is derived from the other channel's
    // valid and the pointer only, never from its own valid, so the two readies are only
    // both high when at most one side is valid and the accepts stay mutually exclusive.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        in0_ready    = 1'b0;
        in1_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in0_ready = pipe_ready && (!in1_valid || last_grant_q);
                in1_ready = pipe_ready && (!in0_valid || !last_grant_q);
            end
            ST_BUSY0: in0_ready = pipe_ready;
            ST_BUSY1: in1_ready = pipe_ready;
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (acc0) begin
                    last_grant_d = 1'b0;
                    if (!in0_endofpacket) begin
                        state_d = ST_BUSY0;
                    end
                end else if (acc1) begin
                    last_grant_d = 1'b1;
                    if (!in1_endofpacket) begin
                        state_d = ST_BUSY1;
                    end
                end
            end
            ST_BUSY0: begin
                if (acc0 && in0_endofpacket) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY1: begin
                if (acc1 && in1_endofpacket) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output register slice; payload is held while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_channel_q <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_empty_q   <= '0;
        end else if (acc0 || acc1) begin
            out_valid_q   <= 1'b1;
            out_channel_q <= acc1;
            out_data_q    <= acc1 ? in1_data          : in0_data;
            out_sop_q     <= acc1 ? in1_startofpacket : in0_startofpacket;
            out_eop_q     <= acc1 ? in1_endofpacket   : in0_endofpacket;
            out_empty_q   <= acc1 ? in1_empty         : in0_empty;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_channel       = out_channel_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_empty         = out_empty_q;

`ifdef SONIC_VC_ARB_PKT_COUNT_EN
    logic [31:0] pkt_count0_q;
    logic [31:0] pkt_count1_q;

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || pkt_count_clear) begin
            pkt_count0_q <= '0;
            pkt_count1_q <= '0;
        end else begin
            if (acc0 && in0_endofpacket) begin
                pkt_count0_q <= pkt_count0_q + 32'd1;
            end
            if (acc1 && in1_endofpacket) begin
                pkt_count1_q <= pkt_count1_q + 32'd1;
            end
        end
    end

    assign pkt_count0 = pkt_count0_q;
    assign pkt_count1 = pkt_count1_q;
`endif

endmodule

// File: tb/tb_sonic_vc_packet_arbiter.sv
// tb/tb_sonic_vc_packet_arbiter.sv - scoreboard bench for sonic_vc_packet_arbiter

module tb_sonic_vc_packet_arbiter;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [1:0]   empty;
        int           gap;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid [2];
    logic [127:0] in_data  [2];
    logic         in_sop   [2];
    logic         in_eop   [2];
    logic [1:0]   in_empty [2];
    logic         in0_ready, in1_ready;
    logic         out_valid, out_ready, out_channel;
    logic [127:0] out_data;
    logic         out_startofpacket, out_endofpacket;
    logic [1:0]   out_empty;
`ifdef SONIC_VC_ARB_PKT_COUNT_EN
    logic         pkt_count_clear;
    logic [31:0]  pkt_count0, pkt_count1;
`endif

    beat_t        tx0_q[$];
    beat_t        tx1_q[$];
    logic [159:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    sonic_vc_packet_arbiter #(.DATA_WIDTH(128), .EMPTY_WIDTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .in0_valid         (in_valid[0]),
        .in0_ready         (in0_ready),
        .in0_data          (in_data[0]),
        .in0_startofpacket (in_sop[0]),
        .in0_endofpacket   (in_eop[0]),
        .in0_empty         (in_empty[0]),
        .in1_valid         (in_valid[1]),
        .in1_ready         (in1_ready),
        .in1_data          (in_data[1]),
        .in1_startofpacket (in_sop[1]),
        .in1_endofpacket   (in_eop[1]),
        .in1_empty         (in_empty[1]),
`ifdef SONIC_VC_ARB_PKT_COUNT_EN
        .pkt_count_clear   (pkt_count_clear),
        .pkt_count0        (pkt_count0),
        .pkt_count1        (pkt_count1),
`endif
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_channel       (out_channel),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [159:0] pack(input logic ch, input logic sop, input logic eop,
                                          input logic [1:0] empty, input logic [127:0] data);
        return {27'd0, ch, sop, eop, empty, data};
    endfunction

    function automatic int tx_size(input int ch);
        return (ch == 0) ? tx0_q.size() : tx1_q.size();
    endfunction

    function automatic beat_t tx_head(input int ch);
        return (ch == 0) ? tx0_q[0] : tx1_q[0];
    endfunction

    task automatic tx_pop(input int ch);
        beat_t b;
        if (ch == 0) b = tx0_q.pop_front();
        else         b = tx1_q.pop_front();
    endtask

    // Queue a packet for a channel and record its beats as the next expected outputs.
    task automatic send_pkt(input int ch, input int n, input logic [127:0] base,
                            input int gap_at, input int gap, input logic [1:0] last_empty);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = base + 128'(i);
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.empty = (i == n - 1) ? last_empty : 2'd0;
            b.gap   = (i == gap_at) ? gap : 0;
            if (ch == 0) tx0_q.push_back(b);
            else         tx1_q.push_back(b);
            exp_q.push_back(pack(ch[0], b.sop, b.eop, b.empty, b.data));
        end
    endtask

    task automatic pre_edge();
        @(negedge clk);
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tx0_q.delete();
        tx1_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tx0_q.size() == 0 && tx1_q.size() == 0 && exp_q.size() == 0) break;
            pre_edge();
        end
        check_eq("drain_exp", exp_q.size(), 0);
        check_eq("drain_tx", tx0_q.size() + tx1_q.size(), 0);
    endtask

    task automatic run_driver(input int ch);
        beat_t b;
        int    gap_left;
        bit    fresh;
        bit    acc;
        fresh         = 1'b1;
        gap_left      = 0;
        in_valid[ch]  = 1'b0;
        in_data[ch]   = '0;
        in_sop[ch]    = 1'b0;
        in_eop[ch]    = 1'b0;
        in_empty[ch]  = '0;
        forever begin
            @(negedge clk);
            in_valid[ch] = 1'b0;
            if (reset || tx_size(ch) == 0) begin
                fresh = 1'b1;
            end else begin
                b = tx_head(ch);
                if (fresh) begin
                    gap_left = b.gap;
                    fresh    = 1'b0;
                end
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    in_valid[ch] = 1'b1;
                    in_data[ch]  = b.data;
                    in_sop[ch]   = b.sop;
                    in_eop[ch]   = b.eop;
                    in_empty[ch] = b.empty;
                end
            end
            #4;
            acc = !reset && in_valid[ch] && ((ch == 0) ? in0_ready : in1_ready);
            @(posedge clk);
            if (acc) begin
                tx_pop(ch);
                fresh = 1'b1;
            end
        end
    endtask

    initial run_driver(0);
    initial run_driver(1);

    // Output monitor: scoreboard compare plus stall-stability and backpressure checks.
    initial begin
        logic [159:0] held, cur, e;
        bit           prev_stall;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            pre_edge();
            cur = pack(out_channel, out_startofpacket, out_endofpacket, out_empty, out_data);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_valid", out_valid, 1);
                    check_eq("stall_hold", cur, held);
                end
                if (out_valid && !out_ready) begin
                    check_eq("stall_in0_ready", in0_ready, 0);
                    check_eq("stall_in1_ready", in1_ready, 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("beat", cur, e);
                    end
                end
                prev_stall = out_valid && !out_ready;
                held       = cur;
            end
        end
    end

    initial begin
        int  n;
        bit  locked;
        bit  done;
        bit  pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        reset     = 1'b1;
        out_ready = 1'b1;
`ifdef SONIC_VC_ARB_PKT_COUNT_EN
        pkt_count_clear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        pre_edge();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_channel", out_channel, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_sop", out_startofpacket, 0);
        check_eq("rst_out_eop", out_endofpacket, 0);
        check_eq("rst_out_empty", out_empty, 0);

        // Basic 3-beat packet on ch0 with one-cycle latency.
        send_pkt(0, 3, 128'h1, -1, 0, 2'd2);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            pre_edge();
            done = in_valid[0] && in0_ready;
        end
        check_eq("basic_accept", done, 1);
        @(posedge clk);
        #1;
        check_eq("basic_lat_valid", out_valid, 1);
        check_eq("basic_lat_data", out_data, 128'h1);
        wait_drain(50);

        // Continuous tie: packets alternate ch0, ch1, ch0, ch1.
        do_reset();
        send_pkt(0, 2, 128'hA0, -1, 0, 2'd0);
        send_pkt(1, 2, 128'hB0, -1, 0, 2'd0);
        send_pkt(0, 2, 128'hA2, -1, 0, 2'd0);
        send_pkt(1, 2, 128'hB2, -1, 0, 2'd0);
        wait_drain(100);

        // Packet lock: ch0 gaps 3 cycles after beat 2, ch1 must stay blocked.
        do_reset();
        send_pkt(0, 4, 128'h40, 2, 3, 2'd1);
        send_pkt(1, 2, 128'h50, -1, 0, 2'd3);
        locked = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            pre_edge();
            if (locked) check_eq("lock_in1_ready", in1_ready, 0);
            if (in_valid[0] && in0_ready) begin
                if (in_sop[0]) locked = 1'b1;
                if (in_eop[0]) begin
                    locked = 1'b0;
                    done   = 1'b1;
                end
            end
        end
        check_eq("lock_eop_seen", done, 1);
        wait_drain(50);

        // Backpressure: out_ready cycles 1,0,0,1.
        do_reset();
        send_pkt(0, 4, 128'h60, -1, 0, 2'd0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            out_ready = pat[i % 4];
            if (exp_q.size() == 0) break;
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain(50);

        // Single-beat packets alternate at full rate.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_pkt(0, 1, 128'hC0 + 128'(i), -1, 0, 2'd0);
            send_pkt(1, 1, 128'hD0 + 128'(i), -1, 0, 2'd0);
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            pre_edge();
            done = out_valid;
        end
        check_eq("single_first", out_valid, 1);
        for (int i = 0; i < 7; i++) begin
            pre_edge();
            check_eq("single_rate", out_valid, 1);
        end
        wait_drain(50);

        // Reset mid 5-beat packet on ch0, then the next tie must go to ch0.
        send_pkt(0, 5, 128'h70, -1, 0, 2'd0);
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            pre_edge();
            if (in_valid[0] && in0_ready) n++;
        end
        check_eq("rst_mid_accepts", n, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tx0_q.delete();
        tx1_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("rst_flush_valid", out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_pkt(0, 1, 128'hE0, -1, 0, 2'd0);
        send_pkt(1, 1, 128'hF0, -1, 0, 2'd0);
        wait_drain(50);

`ifdef SONIC_VC_ARB_PKT_COUNT_EN
        do_reset();
        check_eq("cnt_rst0", pkt_count0, 0);
        check_eq("cnt_rst1", pkt_count1, 0);
        send_pkt(0, 2, 128'h100, -1, 0, 2'd0);
        send_pkt(1, 2, 128'h200, -1, 0, 2'd0);
        send_pkt(0, 2, 128'h110, -1, 0, 2'd0);
        send_pkt(1, 2, 128'h210, -1, 0, 2'd0);
        send_pkt(0, 2, 128'h120, -1, 0, 2'd0);
        wait_drain(100);
        check_eq("cnt0", pkt_count0, 3);
        check_eq("cnt1", pkt_count1, 2);
        send_pkt(0, 1, 128'h130, -1, 0, 2'd0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            pre_edge();
            if (in_valid[0] && in0_ready && in_eop[0]) begin
                pkt_count_clear = 1'b1;
                done = 1'b1;
            end
        end
        check_eq("cnt_clear_hit", done, 1);
        @(posedge clk);
        #1;
        pkt_count_clear = 1'b0;
        check_eq("cnt_clear0", pkt_count0, 0);
        check_eq("cnt_clear1", pkt_count1, 0);
        wait_drain(50);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
